// File: rtl/vm_disp_pkg.sv
// Shared types and constants for the vending-machine display: conversion FSM states,
// 7-segment numeral encodings and value widths.
package vm_disp_pkg;

    localparam int VAL_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [VAL_W-1:0] CLAMP_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [VAL_W-1:0] clamp_value(input logic [VAL_W-1:0] v);
        return (v > CLAMP_MAX) ? CLAMP_MAX : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; one shift per clock, result
// presented for a single COMMIT cycle.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_SHIFT  | adjust-and-shift, VAL_W cycles
//   ST_COMMIT | bcd valid, done high; may restart directly
module bin2bcd_seq
    import vm_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int SH_W = BCD_W + VAL_W;

    conv_state_t     state;
    conv_state_t     state_nxt;
    logic [SH_W-1:0] sh;
    logic [SH_W-1:0] sh_adj;
    logic [3:0]      shift_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (shift_cnt == 4'd1) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_COMMIT);
    end

    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (sh[VAL_W+4*i +: 4] >= 4'd5)
                sh_adj[VAL_W+4*i +: 4] = sh[VAL_W+4*i +: 4] + 4'd3;
    end

    // shift_cnt counts down the remaining shifts; terminal count 1 ends SHIFT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh        <= '0;
            shift_cnt <= '0;
        end else if (start && (state != ST_SHIFT)) begin
            sh        <= {{BCD_W{1'b0}}, value};
            shift_cnt <= 4'(VAL_W);
        end else if (state == ST_SHIFT) begin
            sh        <= {sh_adj[SH_W-2:0], 1'b0};
            shift_cnt <= shift_cnt - 4'd1;
        end
    end

    assign bcd = sh[SH_W-1 -: BCD_W];

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment display of a clamped binary amount.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_display
    import vm_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value,
    input  logic             value_vld,
    output logic             busy,
    output logic [7:0]       DIGIT,
    output logic [6:0]       SEG,
    output logic [9:0]       LED
);

    logic             armed;
    logic             vld;
    logic             start;
    logic [VAL_W-1:0] start_val;
    logic             pend_vld;
    logic [VAL_W-1:0] pend_val;
    logic [9:0]       run_led;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] disp_bcd;
    logic [15:0]      scan_cnt;
    logic             scan_wrap;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [3:0]       digit_sel;
    logic [3:0]       lead_zero;
    logic [6:0]       seg_nxt;

    // A strobe on the very first edge after reset release is not trusted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b0;
        else      armed <= 1'b1;
    end

    assign vld       = value_vld & armed;
    assign start     = (vld | pend_vld) & (~conv_busy | conv_done);
    assign start_val = vld ? clamp_value(value) : pend_val;
    assign busy      = conv_busy | pend_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld <= 1'b0;
            pend_val <= '0;
        end else if (start) begin
            pend_vld <= 1'b0;
        end else if (vld) begin
            pend_vld <= 1'b1;
            pend_val <= clamp_value(value);
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (start_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // run_led follows the conversion in flight so LED and digits commit together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_led  <= '0;
            disp_bcd <= '0;
            LED      <= '0;
        end else begin
            if (start) run_led <= start_val[9:0];
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                LED      <= run_led;
            end
        end
    end

    assign scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));
    assign idx_nxt   = scan_wrap ? idx + 2'd1 : idx;
    assign digit_sel = disp_bcd[4*idx_nxt +: 4];

    always_comb begin
        lead_zero = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lead_zero[3] = (disp_bcd[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] & (disp_bcd[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] & (disp_bcd[7:4] == 4'd0);
`endif
        seg_nxt = lead_zero[idx_nxt] ? SEG_BLANK : seg_decode(digit_sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            DIGIT    <= 8'h01;
            SEG      <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
            idx      <= idx_nxt;
            DIGIT    <= {4'b0000, 4'b0001 << idx_nxt};
            SEG      <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4; expectations adapt to
// SEG_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg_scan_display;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [13:0] value     = '0;
    logic        value_vld = 1'b0;
    logic        busy;
    logic [7:0]  DIGIT;
    logic [6:0]  SEG;
    logic [9:0]  LED;

    int n_total = 0;
    int n_bad   = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    seg_scan_display #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .value_vld (value_vld),
        .busy      (busy),
        .DIGIT     (DIGIT),
        .SEG       (SEG),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [13:0] v);
        @(posedge clk); #1;
        value     = v;
        value_vld = 1'b1;
        @(posedge clk); #1;
        value_vld = 1'b0;
    endtask

    task automatic busy_len(input int exp_len);
        int len = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) len++;
            else break;
        end
        check_val("busy_len", 32'(len), 32'(exp_len));
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_digit"}, 32'(DIGIT), 32'h01);
        check_val({tag, "_seg"},   32'(SEG),   32'h3F);
        check_val({tag, "_led"},   32'(LED),   32'h0);
        check_val({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    // s0 is the ones digit (DIGIT=01) .. s3 the thousands digit (DIGIT=08)
    task automatic check_digits(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        int waited = 0;
        exp_seg = '{s0, s1, s2, s3};
        while (DIGIT !== 8'h08 && waited < 64) begin @(negedge clk); waited++; end
        while (DIGIT === 8'h08 && waited < 64) begin @(negedge clk); waited++; end
        check_val({tag, "_sync"}, 32'(waited < 64), 32'd1);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                check_val({tag, "_digit"}, 32'(DIGIT), 32'(1) << d);
                check_val({tag, "_seg"},   32'(SEG),   32'(exp_seg[d]));
                @(negedge clk);
            end
        end
        check_val({tag, "_wrap"}, 32'(DIGIT), 32'h01);
    endtask

    initial begin
        int t5;
        int t42;
        int last_busy;
        int gap;
        int viol;

        // reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("rst_rel");
        repeat (3) @(posedge clk);

        // 1234: 15 busy clocks, digits 4/3/2/1
        strobe(14'd1234);
        busy_len(15);
        check_val("led_1234", 32'(LED), 32'd210);
        check_digits("v1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

        // 12000 clamps to 9999
        strobe(14'd12000);
        busy_len(15);
        check_val("led_12000", 32'(LED), 32'd783);
        check_digits("v12000", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        // 5 then 42 three clocks later; 42 queued and committed 15 clocks after 5
        @(posedge clk); #1;
        value = 14'd5; value_vld = 1'b1;
        @(posedge clk); #1;
        value_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        value = 14'd42; value_vld = 1'b1;
        @(posedge clk); #1;
        value_vld = 1'b0;
        t5 = -1; t42 = -1; last_busy = -1; gap = 0;
        for (int n = 3; n <= 40; n++) begin
            @(negedge clk);
            if (busy) last_busy = n;
            else if (n < 30) gap = 1;
            if (LED == 10'd5 && t5 < 0) t5 = n;
            if (LED == 10'd42 && t42 < 0) t42 = n;
        end
        check_val("pend_t5",   32'(t5),        32'd15);
        check_val("pend_t42",  32'(t42),       32'd30);
        check_val("pend_gap",  32'(gap),       32'd0);
        check_val("pend_busy", 32'(last_busy), 32'd29);
        check_digits("v42", 7'h5B, 7'h66, LZ, LZ);

        // 7: leading-zero handling
        strobe(14'd7);
        busy_len(15);
        check_val("led_7", 32'(LED), 32'd7);
        check_digits("v7", 7'h07, LZ, LZ, LZ);

        // reset during SHIFT of 8888
        strobe(14'd8888);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        viol = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (LED !== 10'd0 || busy !== 1'b0) viol++;
        end
        check_val("no_8888", 32'(viol), 32'd0);
        check_digits("v0", 7'h3F, LZ, LZ, LZ);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
